// File: rtl/ctrl_relogio_pkg.sv
// Shared definitions for the clock mode/sequencing controller.
//   modo_t  : operating mode, encoded as it appears on ctl_modo
//   SEG_MAX : last value of the seconds counter before it wraps
package ctrl_relogio_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_MIN  = 2'b01,
    SET_HOUR = 2'b10
  } modo_t;

  localparam logic [5:0] SEG_MAX = 6'd59;

endpackage

// File: rtl/ctrl_botao.sv
// Button conditioning: 2-FF synchronizer, rising-edge detector and auto-repeat.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   botao   : raw button, active high, asynchronous to clk
//   enable  : allows arming/auto-repeat; low clears the repeat state
//   pulso   : one-cycle event (edge or auto-repeat), decoded from registers
module ctrl_botao #(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao,
  input  logic enable,
  output logic pulso
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic          sync1;
  logic          sync2;
  logic          sync2_d;
  logic          armed;
  logic          em_repeticao;
  logic [CW-1:0] cnt;
  logic          evento;
  logic          repete;

  assign evento = sync2 & ~sync2_d;

  // Repeat only while the press that armed us is still held; the first
  // repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
  assign repete = enable & armed & sync2 &
                  (em_repeticao ? (cnt == CW'(REPEAT_PERIOD - 1))
                                : (cnt == CW'(REPEAT_DELAY - 1)));

  assign pulso = evento | repete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync2_d      <= 1'b0;
      armed        <= 1'b0;
      em_repeticao <= 1'b0;
      cnt          <= '0;
    end else begin
      sync1   <= botao;
      sync2   <= sync1;
      sync2_d <= sync2;
      if (!enable || !sync2) begin
        armed        <= 1'b0;
        em_repeticao <= 1'b0;
        cnt          <= '0;
      end else if (evento) begin
        armed        <= 1'b1;
        em_repeticao <= 1'b0;
        cnt          <= '0;
      end else if (armed) begin
        if (repete) begin
          em_repeticao <= 1'b1;
          cnt          <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ctrl_ajuste_relogio.sv
// Mode and sequencing controller for the digital clock minute/hour datapath.
//   ctl_clock / ctl_reset       : clock (rising edge) and async active-low reset
//   ctl_btn_mode / ctl_btn_inc  : raw buttons, active high, asynchronous
//   ctl_carry_min               : hour-carry level flag from the minute counter
//   ctl_min_enable/_incremento  : enable and one-cycle increment to minute counter
//   ctl_hora_enable/_incremento : enable and one-cycle increment to hour counter
//   ctl_seg                     : seconds 0..59
//   ctl_modo                    : 00 RUN, 01 SET_MIN, 10 SET_HOUR
//   ctl_blink_min/_hora         : high while the respective digits are blanked
module ctrl_ajuste_relogio
  import ctrl_relogio_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned BLINK_HALF    = 12_500_000
) (
  input  logic       ctl_clock,
  input  logic       ctl_reset,
  input  logic       ctl_btn_mode,
  input  logic       ctl_btn_inc,
  input  logic       ctl_carry_min,
  output logic       ctl_min_enable,
  output logic       ctl_min_incremento,
  output logic       ctl_hora_enable,
  output logic       ctl_hora_incremento,
  output logic [5:0] ctl_seg,
  output logic [1:0] ctl_modo,
  output logic       ctl_blink_min,
  output logic       ctl_blink_hora
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  modo_t         modo;
  modo_t         modo_n;
  logic [PW-1:0] pre;
  logic          tick;
  logic          carry_d;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_n;
  logic          fase;
  logic          fase_n;
  logic          ev_modo;
  logic          ev_inc;
  logic          inc_en;
  logic          min_n;
  logic          hora_n;

  // A coincident mode event also disarms the inc button's auto-repeat.
  assign inc_en = (modo != RUN) & ~ev_modo;

  ctrl_botao #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_botao_modo (
    .clk    (ctl_clock),
    .rst_n  (ctl_reset),
    .botao  (ctl_btn_mode),
    .enable (1'b0),
    .pulso  (ev_modo)
  );

  ctrl_botao #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_botao_inc (
    .clk    (ctl_clock),
    .rst_n  (ctl_reset),
    .botao  (ctl_btn_inc),
    .enable (inc_en),
    .pulso  (ev_inc)
  );

  assign ctl_modo = modo;

  always_comb begin
    modo_n = modo;
    case (modo)
      RUN:      if (ev_modo) modo_n = SET_MIN;
      SET_MIN:  if (ev_modo) modo_n = SET_HOUR;
      SET_HOUR: if (ev_modo) modo_n = RUN;
      default:  modo_n = RUN;
    endcase

    tick   = (pre == PW'(CLK_FREQ - 1));
    min_n  = 1'b0;
    hora_n = 1'b0;
    if (modo == RUN) begin
      // The wrap pulse is issued even if a mode event leaves RUN this cycle.
      min_n  = tick & (ctl_seg == SEG_MAX);
      hora_n = ctl_carry_min & ~carry_d;
    end else if (ev_inc && !ev_modo) begin
      if (modo == SET_MIN)  min_n  = 1'b1;
      if (modo == SET_HOUR) hora_n = 1'b1;
    end
    min_n  = min_n  & ~ctl_min_incremento;
    hora_n = hora_n & ~ctl_hora_incremento;

    if (min_n || hora_n) begin
      bcnt_n = '0;
      fase_n = 1'b0;
    end else if (bcnt == BW'(BLINK_HALF - 1)) begin
      bcnt_n = '0;
      fase_n = ~fase;
    end else begin
      bcnt_n = bcnt + BW'(1);
      fase_n = fase;
    end
  end

  always_ff @(posedge ctl_clock or negedge ctl_reset) begin
    if (!ctl_reset) begin
      modo                <= RUN;
      pre                 <= '0;
      ctl_seg             <= '0;
      carry_d             <= 1'b0;
      bcnt                <= '0;
      fase                <= 1'b0;
      ctl_min_incremento  <= 1'b0;
      ctl_hora_incremento <= 1'b0;
      ctl_min_enable      <= 1'b1;
      ctl_hora_enable     <= 1'b1;
      ctl_blink_min       <= 1'b0;
      ctl_blink_hora      <= 1'b0;
    end else begin
      modo    <= modo_n;
      carry_d <= ctl_carry_min;

      if (modo != RUN || ev_modo) begin
        pre     <= '0;
        ctl_seg <= '0;
      end else if (tick) begin
        pre     <= '0;
        ctl_seg <= (ctl_seg == SEG_MAX) ? '0 : ctl_seg + 6'd1;
      end else begin
        pre <= pre + PW'(1);
      end

      ctl_min_incremento  <= min_n;
      ctl_hora_incremento <= hora_n;
      ctl_min_enable      <= (modo_n != SET_HOUR);
      ctl_hora_enable     <= 1'b1;

      bcnt           <= bcnt_n;
      fase           <= fase_n;
      ctl_blink_min  <= (modo_n == SET_MIN)  & fase_n;
      ctl_blink_hora <= (modo_n == SET_HOUR) & fase_n;
    end
  end

endmodule

// File: tb/tb_ctrl_ajuste_relogio.sv
// Self-checking bench for ctrl_ajuste_relogio with small timing parameters.
module tb_ctrl_ajuste_relogio;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       carry;
  logic       min_en;
  logic       min_inc;
  logic       hora_en;
  logic       hora_inc;
  logic [5:0] seg;
  logic [1:0] modo;
  logic       blink_min;
  logic       blink_hora;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int min_seen = 0;
  int hora_seen = 0;
  int exp_min[$];
  int exp_hora[$];
  logic em;
  logic eh;

  typedef struct {
    int         at;
    logic       carry;
    logic [5:0] seg;
    logic [1:0] modo;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  ctrl_ajuste_relogio #(
    .CLK_FREQ      (4),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (2),
    .BLINK_HALF    (3)
  ) dut (
    .ctl_clock           (clk),
    .ctl_reset           (rst),
    .ctl_btn_mode        (btn_mode),
    .ctl_btn_inc         (btn_inc),
    .ctl_carry_min       (carry),
    .ctl_min_enable      (min_en),
    .ctl_min_incremento  (min_inc),
    .ctl_hora_enable     (hora_en),
    .ctl_hora_incremento (hora_inc),
    .ctl_seg             (seg),
    .ctl_modo            (modo),
    .ctl_blink_min       (blink_min),
    .ctl_blink_hora      (blink_hora)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick_n(2);
    btn_mode = 1'b0;
    tick_n(4);
  endtask

  // Scoreboard: expected pulse cycles are queued by the stimulus.
  always @(negedge clk) begin
    em = (exp_min.size() > 0) && (exp_min[0] <= cyc);
    if (em) void'(exp_min.pop_front());
    if (em || min_inc) check($sformatf("min_pulse@%0d", cyc), int'(min_inc), int'(em));
    eh = (exp_hora.size() > 0) && (exp_hora[0] <= cyc);
    if (eh) void'(exp_hora.pop_front());
    if (eh || hora_inc) check($sformatf("hora_pulse@%0d", cyc), int'(hora_inc), int'(eh));
    if (min_inc)  min_seen++;
    if (hora_inc) hora_seen++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int r, c, m0, h0;
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; carry = 1'b0;

    // {cycle offset after release, carry input, expected seg, expected mode}
    vecs[0]  = '{0,   1'b0, 6'd0,  2'd0};
    vecs[1]  = '{3,   1'b0, 6'd0,  2'd0};
    vecs[2]  = '{4,   1'b0, 6'd1,  2'd0};
    vecs[3]  = '{7,   1'b0, 6'd1,  2'd0};
    vecs[4]  = '{8,   1'b0, 6'd2,  2'd0};
    vecs[5]  = '{100, 1'b0, 6'd25, 2'd0};
    vecs[6]  = '{236, 1'b0, 6'd59, 2'd0};
    vecs[7]  = '{239, 1'b0, 6'd59, 2'd0};
    vecs[8]  = '{240, 1'b0, 6'd0,  2'd0};
    vecs[9]  = '{243, 1'b0, 6'd0,  2'd0};
    vecs[10] = '{244, 1'b1, 6'd1,  2'd0};
    vecs[11] = '{250, 1'b1, 6'd2,  2'd0};
    vecs[12] = '{254, 1'b0, 6'd3,  2'd0};

    tick_n(2);
    check("rst_seg", int'(seg), 0);
    check("rst_modo", int'(modo), 0);
    check("rst_min_inc", int'(min_inc), 0);
    check("rst_hora_inc", int'(hora_inc), 0);
    check("rst_min_en", int'(min_en), 1);
    check("rst_hora_en", int'(hora_en), 1);
    check("rst_blink_min", int'(blink_min), 0);
    check("rst_blink_hora", int'(blink_hora), 0);

    // RUN: seconds walk, minute wrap pulse, hour carry edge
    rst = 1'b1;
    r = cyc;
    exp_min.push_back(r + 240);
    m0 = min_seen; h0 = hora_seen;
    for (int i = 0; i < NV; i++) begin
      while (cyc < r + vecs[i].at) @(negedge clk);
      check($sformatf("vec%0d_seg", i), int'(seg), int'(vecs[i].seg));
      check($sformatf("vec%0d_modo", i), int'(modo), int'(vecs[i].modo));
      if (vecs[i].carry && !carry) exp_hora.push_back(cyc + 1);
      carry = vecs[i].carry;
    end
    check("run_min_pulses", min_seen - m0, 1);
    check("run_hora_pulses", hora_seen - h0, 1);

    // SET_MIN: three presses, blink, carry consumed
    press_mode();
    check("set_min_modo", int'(modo), 1);
    check("set_min_seg", int'(seg), 0);
    check("set_min_en", int'(min_en), 1);
    m0 = min_seen;
    for (int i = 0; i < 3; i++) begin
      exp_min.push_back(cyc + 3);
      btn_inc = 1'b1; tick_n(2); btn_inc = 1'b0; tick_n(4);
    end
    check("blink_min_on", int'(blink_min), 1);
    check("blink_hora_off_in_min", int'(blink_hora), 0);
    tick_n(3);
    check("blink_min_off", int'(blink_min), 0);
    check("set_min_pulses", min_seen - m0, 3);
    h0 = hora_seen;
    carry = 1'b1; tick_n(6); carry = 1'b0; tick_n(3);
    check("no_hora_in_set_min", hora_seen - h0, 0);
    check("set_min_seg_held", int'(seg), 0);

    // SET_HOUR: held inc with auto-repeat
    press_mode();
    check("set_hour_modo", int'(modo), 2);
    check("set_hour_min_en", int'(min_en), 0);
    check("set_hour_hora_en", int'(hora_en), 1);
    h0 = hora_seen; c = cyc;
    exp_hora.push_back(c + 3);
    for (int k = 11; k <= 19; k += 2) exp_hora.push_back(c + k);
    btn_inc = 1'b1; tick_n(18); btn_inc = 1'b0; tick_n(10);
    check("set_hour_pulses", hora_seen - h0, 6);
    check("blink_hora_on", int'(blink_hora), 1);
    check("blink_min_off_in_hour", int'(blink_min), 0);

    // Coincident mode and inc events
    press_mode();
    check("back_to_run", int'(modo), 0);
    m0 = min_seen; h0 = hora_seen;
    btn_mode = 1'b1; btn_inc = 1'b1; tick_n(12);
    btn_mode = 1'b0; btn_inc = 1'b0; tick_n(6);
    check("coinc_run_modo", int'(modo), 1);
    btn_mode = 1'b1; btn_inc = 1'b1; tick_n(3);
    btn_mode = 1'b0; btn_inc = 1'b0; tick_n(4);
    check("coinc_min_modo", int'(modo), 2);
    check("coinc_min_pulses", min_seen - m0, 0);
    check("coinc_hora_pulses", hora_seen - h0, 0);
    btn_mode = 1'b1; tick_n(2); btn_mode = 1'b0; tick_n(1);
    check("third_press_modo", int'(modo), 0);
    check("restart_seg0", int'(seg), 0);
    tick_n(3);
    check("restart_seg_c6", int'(seg), 0);
    tick_n(1);
    check("restart_seg_c7", int'(seg), 1);
    tick_n(4);
    check("restart_seg_c11", int'(seg), 2);

    // Reset during auto-repeat in SET_HOUR
    press_mode();
    press_mode();
    check("pre_reset_modo", int'(modo), 2);
    c = cyc;
    exp_hora.push_back(c + 3);
    exp_hora.push_back(c + 11);
    btn_inc = 1'b1; tick_n(11);
    #1 rst = 1'b0;
    #1;
    check("async_rst_hora_inc", int'(hora_inc), 0);
    check("async_rst_modo", int'(modo), 0);
    check("async_rst_seg", int'(seg), 0);
    check("async_rst_min_en", int'(min_en), 1);
    check("async_rst_blink_hora", int'(blink_hora), 0);
    @(negedge clk);
    btn_inc = 1'b0; tick_n(3);
    rst = 1'b1;
    m0 = min_seen; h0 = hora_seen;
    tick_n(20);
    check("post_rst_min_pulses", min_seen - m0, 0);
    check("post_rst_hora_pulses", hora_seen - h0, 0);
    check("post_rst_modo", int'(modo), 0);

    check("pending_pulses", exp_min.size() + exp_hora.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
